btn_event_arbiter: RTL and testbench

BTN_EVENT_ARBITER -- requirements
Module: btn_event_arbiter

---
 rtl/btn_event_arbiter_pkg.sv | 51 +++++
 rtl/btn_evt_fifo.sv | 73 +++++++
 rtl/btn_event_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_btn_event_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_event_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_event_arbiter_pkg
// Description : Shared coprocessor definitions for button events. Holds the
//               event type encodings, the packed {btn, type} event record and
//               the per-button edge/hold classification helper.
// Revision    : 1.0  initial release
// ============================================================================
package btn_event_arbiter_pkg;

  // Widest button index an event record can carry. Narrower designs
  // zero-extend into this field.
  localparam int EVT_BTN_W = 8;

  typedef enum logic [1:0] {
    EVT_NONE    = 2'b00,
    EVT_PRESS   = 2'b01,
    EVT_RELEASE = 2'b10,
    EVT_HOLD    = 2'b11
  } evt_type_e;

  typedef struct packed {
    logic [EVT_BTN_W-1:0] btn;
    evt_type_e            etype;
  } btn_evt_t;

  localparam int EVT_W = $bits(btn_evt_t);

  // Edges take priority over HOLD. A HOLD can never coincide with an edge
  // in practice: the hold count is zero on a rising edge and a hold needs
  // the level to be high, which excludes a falling edge.
  function automatic evt_type_e detect_event(
    input logic armed,
    input logic prev,
    input logic cur,
    input logic hold_hit
  );
    evt_type_e evt;
    evt = EVT_NONE;
    if (armed && cur && !prev) begin
      evt = EVT_PRESS;
    end else if (armed && !cur && prev) begin
      evt = EVT_RELEASE;
    end else if (hold_hit) begin
      evt = EVT_HOLD;
    end
    return evt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_evt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : btn_evt_fifo
// Description : Synchronous event FIFO with valid/ready on both sides. A push
//               is accepted while full if a pop happens in the same cycle.
//               Head data comes straight from registered storage.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               in_valid/in_data/in_ready    - write side
//               out_valid/out_data/out_ready - read side (head of queue)
// Revision    : 1.0  initial release
// ============================================================================
module btn_evt_fifo
  import btn_event_arbiter_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = EVT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic w_push;
  logic w_pop;

  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid && out_ready;
  // Ready does not depend on in_valid, so the producer may use it to decide
  // whether to push without forming a combinational loop.
  assign in_ready  = (r_count != CW'(DEPTH)) || w_pop;
  assign w_push    = in_valid && in_ready;
  assign out_data  = r_mem[r_rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= in_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/btn_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : btn_event_arbiter
// Description : Turns debounced button levels into PRESS / RELEASE / HOLD
//               events, parks each in a per-button pending slot, and moves
//               one slot per cycle (round-robin) into an event FIFO.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               btn_db        - debounced levels, 1 = pressed
//               evt_ready     - consumer accepts head event
//               clr_overflow  - one-cycle clear of evt_overflow
//               evt_valid     - queue non-empty
//               evt_btn       - button index of head event
//               evt_type      - head event type (01 PRESS, 10 RELEASE, 11 HOLD)
//               evt_overflow  - sticky: at least one event was overwritten
// Revision    : 1.0  initial release
// ============================================================================
module btn_event_arbiter
  import btn_event_arbiter_pkg::*;
#(
  parameter int NUM_BTN     = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 25000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_BTN-1:0]         btn_db,
  input  logic                       evt_ready,
  input  logic                       clr_overflow,
  output logic                       evt_valid,
  output logic [$clog2(NUM_BTN)-1:0] evt_btn,
  output logic [1:0]                 evt_type,
  output logic                       evt_overflow
);

  // NUM_BTN must be at least 2 so that the button index has a non-zero width.
  localparam int BTN_W = $clog2(NUM_BTN);
  localparam int HCW   = $clog2(HOLD_CYCLES + 1);

  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);
  localparam logic [HCW-1:0] HOLD_SAT  = HCW'(HOLD_CYCLES);

  logic [NUM_BTN-1:0]      r_prev;
  logic                    r_armed;
  logic [BTN_W-1:0]        r_rr_ptr;
  logic                    r_overflow;

  logic [NUM_BTN-1:0][1:0] w_slot;
  logic [NUM_BTN-1:0][1:0] w_new_evt;
  logic [NUM_BTN-1:0]      w_grant_vec;
  logic [NUM_BTN-1:0]      w_drop;

  logic                    w_grant;
  logic [BTN_W-1:0]        w_grant_idx;
  logic                    w_fifo_ready;
  btn_evt_t                w_push_evt;
  logic [EVT_W-1:0]        w_fifo_dout;
  btn_evt_t                w_head_evt;

  // --------------------------------------------------------------------------
  // Edge reference. r_armed stays low through reset and for the first edge
  // after it, so a button already held when reset releases only loads r_prev
  // and never produces a PRESS.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    r_prev <= btn_db;
    if (rst) begin
      r_armed <= 1'b0;
    end else begin
      r_armed <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Per-button hold counter, event detection and pending slot.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    logic [HCW-1:0] r_hold_cnt;
    logic [1:0]     r_slot;
    logic           w_hold_hit;

    // The counter saturates one past HOLD_LAST, so the hit fires exactly once
    // per press: on the HOLD_CYCLES-th consecutive pressed sample.
    assign w_hold_hit      = btn_db[gi] && (r_hold_cnt == HOLD_LAST);
    assign w_new_evt[gi]   = detect_event(r_armed, r_prev[gi], btn_db[gi], w_hold_hit);
    assign w_slot[gi]      = r_slot;
    assign w_grant_vec[gi] = w_grant && (w_grant_idx == BTN_W'(gi));
    // A slot that is being granted this cycle is free to take the new event.
    assign w_drop[gi]      = (w_new_evt[gi] != EVT_NONE) && (r_slot != EVT_NONE) &&
                             !w_grant_vec[gi];

    always_ff @(posedge clk) begin
      if (rst) begin
        r_hold_cnt <= '0;
      end else if (!btn_db[gi]) begin
        r_hold_cnt <= '0;
      end else if (r_hold_cnt != HOLD_SAT) begin
        r_hold_cnt <= r_hold_cnt + HCW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_slot <= EVT_NONE;
      end else if (w_new_evt[gi] != EVT_NONE) begin
        r_slot <= w_new_evt[gi];
      end else if (w_grant_vec[gi]) begin
        r_slot <= EVT_NONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Round-robin grant: scan from r_rr_ptr upward, wrapping at NUM_BTN.
  // Nothing is granted unless the FIFO can take the event this cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    int               idx;
    logic [BTN_W-1:0] idx_b;
    w_grant     = 1'b0;
    w_grant_idx = '0;
    idx         = 0;
    idx_b       = '0;
    for (int off = 0; off < NUM_BTN; off++) begin
      idx   = (int'(r_rr_ptr) + off) % NUM_BTN;
      idx_b = BTN_W'(idx);
      if (!w_grant && w_fifo_ready && (w_slot[idx_b] != EVT_NONE)) begin
        w_grant     = 1'b1;
        w_grant_idx = idx_b;
      end
    end
  end

  always_comb begin
    w_push_evt       = '0;
    w_push_evt.btn   = EVT_BTN_W'(w_grant_idx);
    w_push_evt.etype = evt_type_e'(w_slot[w_grant_idx]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      if (w_grant_idx == BTN_W'(NUM_BTN - 1)) begin
        r_rr_ptr <= '0;
      end else begin
        r_rr_ptr <= w_grant_idx + BTN_W'(1);
      end
    end
  end

  // Setting beats clearing when both happen in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (|w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Event queue
  // --------------------------------------------------------------------------
  btn_evt_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (EVT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_grant),
    .in_data   (w_push_evt),
    .in_ready  (w_fifo_ready),
    .out_valid (evt_valid),
    .out_data  (w_fifo_dout),
    .out_ready (evt_ready)
  );

  assign w_head_evt   = w_fifo_dout;
  assign evt_btn      = w_head_evt.btn[BTN_W-1:0];
  assign evt_type     = w_head_evt.etype;
  assign evt_overflow = r_overflow;

  // Upper index bits of the event record are always zero here.
  if (BTN_W < EVT_BTN_W) begin : g_btn_hi
    logic w_unused_btn_hi;
    assign w_unused_btn_hi = |w_head_evt.btn[EVT_BTN_W-1:BTN_W];
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_event_arbiter
// Description : Self-checking bench for btn_event_arbiter (4 buttons, depth 4,
//               hold after 8 cycles): vector table, directed corner
//               sequences and a randomized run against a queue-based model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_btn_event_arbiter;

  localparam int NB    = 4;
  localparam int DEPTH = 4;
  localparam int HOLD  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_db;
  logic          evt_ready;
  logic          clr_overflow;
  logic          evt_valid;
  logic [1:0]    evt_btn;
  logic [1:0]    evt_type;
  logic          evt_overflow;

  always #5 clk = ~clk;

  btn_event_arbiter #(
    .NUM_BTN     (NB),
    .FIFO_DEPTH  (DEPTH),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_db       (btn_db),
    .evt_ready    (evt_ready),
    .clr_overflow (clr_overflow),
    .evt_valid    (evt_valid),
    .evt_btn      (evt_btn),
    .evt_type     (evt_type),
    .evt_overflow (evt_overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: pending events per button, a queue for the FIFO,
  // and a count of consecutive pressed samples per button.
  // --------------------------------------------------------------------------
  int          m_slot [NB];
  int          m_run  [NB];
  logic [NB-1:0] m_prev;
  bit          m_armed;
  int          m_next;
  bit          m_ovf;
  logic [3:0]  m_q [$];

  function automatic void model_edge(input logic r, input logic [NB-1:0] b,
                                     input logic rd, input logic cl);
    int  newev [NB];
    int  g;
    bit  pop;
    bit  room;
    bit  lost;
    logic [1:0] gb;
    logic [1:0] gt;
    if (r) begin
      m_q.delete();
      for (int i = 0; i < NB; i++) begin
        m_slot[i] = 0;
        m_run[i]  = 0;
      end
      m_next  = 0;
      m_ovf   = 1'b0;
      m_armed = 1'b0;
      m_prev  = b;
      return;
    end
    pop  = (m_q.size() > 0) && rd;
    room = (m_q.size() < DEPTH) || pop;
    g    = -1;
    if (room) begin
      for (int j = 0; j < NB; j++) begin
        if (g < 0 && m_slot[(m_next + j) % NB] != 0) g = (m_next + j) % NB;
      end
    end
    for (int i = 0; i < NB; i++) begin
      newev[i] = 0;
      if (m_armed && b[i] && !m_prev[i])      newev[i] = 1;
      else if (m_armed && !b[i] && m_prev[i]) newev[i] = 2;
      else if (b[i] && (m_run[i] + 1 == HOLD)) newev[i] = 3;
      m_run[i] = b[i] ? ((m_run[i] < HOLD) ? m_run[i] + 1 : HOLD) : 0;
    end
    if (pop) void'(m_q.pop_front());
    if (g >= 0) begin
      gb = 2'(g);
      gt = 2'(m_slot[g]);
      m_q.push_back({gb, gt});
      m_next = (g + 1) % NB;
    end
    lost = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (newev[i] != 0) begin
        if (m_slot[i] != 0 && i != g) lost = 1'b1;
        m_slot[i] = newev[i];
      end else if (i == g) begin
        m_slot[i] = 0;
      end
    end
    if (lost) m_ovf = 1'b1;
    else if (cl) m_ovf = 1'b0;
    m_prev  = b;
    m_armed = 1'b1;
  endfunction

  task automatic compare_model();
    logic [3:0] head;
    chk("mdl_valid", 32'(evt_valid), 32'(m_q.size() > 0));
    chk("mdl_overflow", 32'(evt_overflow), 32'(m_ovf));
    if (m_q.size() > 0) begin
      head = m_q[0];
      chk("mdl_btn", 32'(evt_btn), 32'(head[3:2]));
      chk("mdl_type", 32'(evt_type), 32'(head[1:0]));
    end
  endtask

  task automatic step(input logic r, input logic [NB-1:0] b, input logic rd, input logic cl);
    rst          = r;
    btn_db       = b;
    evt_ready    = rd;
    clr_overflow = cl;
    @(posedge clk);
    model_edge(r, b, rd, cl);
    #1;
    compare_model();
  endtask

  // --------------------------------------------------------------------------
  // Vector table
  // --------------------------------------------------------------------------
  typedef struct {
    logic          r;
    logic [NB-1:0] b;
    logic          rd;
    logic          cl;
    logic          ev;
    logic [1:0]    eb;
    logic [1:0]    et;
    logic          eo;
  } vec_t;

  vec_t tbl [$];

  int         press_cnt;
  int         hold_cnt;
  int         press_at;
  int         hold_at;
  int         bad_press;
  logic [NB-1:0] rb;
  bit         rmode;
  int         k;

  initial begin
    rst          = 1'b1;
    btn_db       = '0;
    evt_ready    = 1'b0;
    clr_overflow = 1'b0;

    //              r     b     rd    cl    ev    eb    et     eo
    // Single press / release of button 0.
    tbl.push_back('{1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 2'b00, 1'b0});
    tbl.push_back('{1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 2'b00, 1'b0});
    tbl.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 2'b00, 1'b0});
    tbl.push_back('{1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 2'd0, 2'b00, 1'b0});
    tbl.push_back('{1'b0, 4'h1, 1'b1, 1'b0, 1'b1, 2'd0, 2'b01, 1'b0});
    tbl.push_back('{1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 2'd0, 2'b00, 1'b0});
    tbl.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 2'b00, 1'b0});
    tbl.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 2'd0, 2'b10, 1'b0});
    tbl.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 2'b00, 1'b0});
    // All four pressed together from a fresh round-robin start.
    tbl.push_back('{1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 2'b00, 1'b0});
    tbl.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 2'b00, 1'b0});
    tbl.push_back('{1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 2'b00, 1'b0});
    tbl.push_back('{1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 2'd0, 2'b01, 1'b0});
    tbl.push_back('{1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 2'd1, 2'b01, 1'b0});
    tbl.push_back('{1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 2'd2, 2'b01, 1'b0});
    tbl.push_back('{1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 2'd3, 2'b01, 1'b0});
    tbl.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 2'b00, 1'b0});
    tbl.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 2'd0, 2'b10, 1'b0});
    tbl.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 2'd1, 2'b10, 1'b0});
    tbl.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 2'd2, 2'b10, 1'b0});
    tbl.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 2'd3, 2'b10, 1'b0});
    tbl.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 2'b00, 1'b0});

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].b, tbl[i].rd, tbl[i].cl);
      chk($sformatf("tbl%0d_valid", i), 32'(evt_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_ovf", i), 32'(evt_overflow), 32'(tbl[i].eo));
      if (tbl[i].ev || tbl[i].r) begin
        chk($sformatf("tbl%0d_btn", i), 32'(evt_btn), 32'(tbl[i].eb));
        chk($sformatf("tbl%0d_type", i), 32'(evt_type), 32'(tbl[i].et));
      end
    end

    // ------------------------------------------------------------------------
    // Button 2 held: one PRESS, exactly one HOLD on the 8th pressed sample.
    // ------------------------------------------------------------------------
    step(1'b1, 4'h0, 1'b1, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    press_cnt = 0;
    hold_cnt  = 0;
    press_at  = -1;
    hold_at   = -1;
    for (int i = 1; i <= 28; i++) begin
      step(1'b0, 4'h4, 1'b1, 1'b0);
      if (evt_valid && evt_btn == 2'd2 && evt_type == 2'b01) begin
        press_cnt++;
        press_at = i;
      end
      if (evt_valid && evt_btn == 2'd2 && evt_type == 2'b11) begin
        hold_cnt++;
        hold_at = i;
      end
    end
    chk("hold_press_count", 32'(press_cnt), 32'd1);
    chk("hold_count", 32'(hold_cnt), 32'd1);
    chk("hold_press_latency", 32'(press_at), 32'd2);
    chk("hold_latency", 32'(hold_at), 32'd9);
    for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 1'b1, 1'b0);

    // ------------------------------------------------------------------------
    // Back-pressure: four events fill the FIFO, a fifth waits in its slot
    // and moves in on the very cycle of a pop.
    // ------------------------------------------------------------------------
    step(1'b1, 4'h0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 4'h1, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 4'h2, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 4'h4, 1'b0, 1'b0);
    step(1'b0, 4'h4, 1'b0, 1'b0);
    chk("full_head_btn", 32'(evt_btn), 32'd0);
    chk("full_head_type", 32'(evt_type), 32'h1);
    chk("full_no_overflow", 32'(evt_overflow), 32'd0);
    step(1'b0, 4'h4, 1'b1, 1'b0);
    chk("pop_head_type", 32'(evt_type), 32'h2);
    chk("pop_no_overflow", 32'(evt_overflow), 32'd0);

    // ------------------------------------------------------------------------
    // Overflow: btn 1 press overwritten by its release while FIFO is full,
    // then clear, then clear colliding with a fresh drop.
    // ------------------------------------------------------------------------
    step(1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 4'h2, 1'b0, 1'b0);
    chk("pending_no_overflow", 32'(evt_overflow), 32'd0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    chk("overwrite_overflow", 32'(evt_overflow), 32'd1);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    chk("clear_overflow", 32'(evt_overflow), 32'd0);
    step(1'b0, 4'h2, 1'b0, 1'b1);
    chk("set_beats_clear", 32'(evt_overflow), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 4'h2, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 4'h0, 1'b1, 1'b0);

    // ------------------------------------------------------------------------
    // Reset mid-operation with buttons 0 and 2 held.
    // ------------------------------------------------------------------------
    step(1'b1, 4'h0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 4'h5, 1'b0, 1'b0);
    step(1'b0, 4'h7, 1'b0, 1'b0);
    step(1'b0, 4'h7, 1'b0, 1'b0);
    step(1'b0, 4'h5, 1'b0, 1'b0);
    chk("queued_before_rst", 32'(evt_valid), 32'd1);
    step(1'b1, 4'h5, 1'b0, 1'b0);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_btn", 32'(evt_btn), 32'd0);
    chk("rst_type", 32'(evt_type), 32'd0);
    bad_press = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'h5, 1'b1, 1'b0);
      if (evt_valid && evt_type == 2'b01 && (evt_btn == 2'd0 || evt_btn == 2'd2)) bad_press++;
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 4'h0, 1'b1, 1'b0);
      if (evt_valid && evt_type == 2'b01 && (evt_btn == 2'd0 || evt_btn == 2'd2)) bad_press++;
    end
    chk("no_press_after_rst", 32'(bad_press), 32'd0);

    // ------------------------------------------------------------------------
    // Randomized traffic against the model.
    // ------------------------------------------------------------------------
    rb    = '0;
    rmode = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        k     = $urandom_range(0, NB - 1);
        rb[k] = ~rb[k];
      end
      if ($urandom_range(0, 31) == 0) rmode = ~rmode;
      step(($urandom_range(0, 399) == 0), rb,
           rmode ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
